// File: rtl/motion_pkg.sv
// ---------------------------------------------------------------------------
// motion_pkg
//   Shared types for the coordinated step generator.
//   - state_t  : profile FSM states
//   - lane_lsb : bit offset of one axis lane inside a flat N_AXES*W bus
// ---------------------------------------------------------------------------
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SELECT,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } state_t;

    // Bit offset of lane `axis` in a flat bus built from `w`-bit lanes.
    function automatic int lane_lsb(input int axis, input int w);
        return axis * w;
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_pulse_gen
//   Stretches a one-cycle fire request into a step pulse that stays high for
//   exactly PULSE_CYCLES clocks.
//   Ports:
//     clk, reset (sync, active-low)
//     fire  in   start a new pulse on the next edge
//     step  out  stepper step pin
//     busy  out  pulse still in progress
// ---------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int PULSE_CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    output logic step,
    output logic busy
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = CW'(PULSE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = (cnt_q != '0);
    assign busy = step;

endmodule

// File: rtl/motion_profile_axes.sv
// ---------------------------------------------------------------------------
// motion_profile_axes
//   N-axis coordinated step generator. One linear move runs a trapezoidal
//   speed profile on the longest (dominant) axis; the other axes follow it
//   by Bresenham DDA so every axis ends together.
//   Ports:
//     clk, reset (sync, active-low)
//     enable_steppers / disable_steppers  1-cycle driver on/off pulses
//     start, ready                        move handshake
//     num, speed, max_speed, acceleration, jerk   move operands (flat buses)
//     endstop_min / endstop_max           active-high limit switches
//     stepper_enable (active-low), stepper_step, stepper_direction
//     done, aborted                       1-cycle completion report
// ---------------------------------------------------------------------------
module motion_profile_axes
    import motion_pkg::*;
#(
    parameter int N_AXES       = 4,
    parameter int W            = 32,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PULSE_CYCLES = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_steppers,
    input  logic                disable_steppers,
    input  logic                start,
    output logic                ready,
    input  logic [N_AXES*W-1:0] num,
    input  logic [W-1:0]        speed,
    input  logic [N_AXES*W-1:0] max_speed,
    input  logic [N_AXES*W-1:0] acceleration,
    input  logic [N_AXES*W-1:0] jerk,
    input  logic [N_AXES-1:0]   endstop_min,
    input  logic [N_AXES-1:0]   endstop_max,
    output logic [N_AXES-1:0]   stepper_enable,
    output logic [N_AXES-1:0]   stepper_step,
    output logic [N_AXES-1:0]   stepper_direction,
    output logic                done,
    output logic                aborted
);

    localparam int         IW    = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam logic [W:0] CLK_F = (W+1)'(CLK_HZ);

    logic [W-1:0] num_a [N_AXES], max_a [N_AXES], accel_a [N_AXES], jerk_a [N_AXES];

    // Control registers
    state_t            state_q, state_d;
    logic              drv_on_q, drv_on_d, abort_q, abort_d;
    logic              done_q, done_d, aborted_q, aborted_d;
    logic [N_AXES-1:0] dir_q, dir_d;

    // Move datapath registers
    logic [W-1:0]  len_q [N_AXES], len_d [N_AXES], max_q [N_AXES], max_d [N_AXES];
    logic [W-1:0]  accel_q [N_AXES], accel_d [N_AXES], jerk_q [N_AXES], jerk_d [N_AXES];
    logic [W:0]    err_q [N_AXES], err_d [N_AXES];
    logic [W-1:0]  speed_q, speed_d, l_q, l_d, v_q, v_d, v0_q, v0_d, vcr_q, vcr_d;
    logic [W-1:0]  cnt_q, cnt_d, accel_steps_q, accel_steps_d;
    logic [W:0]    phase_q, phase_d, vacc_q, vacc_d;
    logic [IW-1:0] dom_q, dom_d;

    // Combinational helpers
    logic              hit, fire_dom, tick;
    logic [W:0]        phase_sum, vacc_sum, e_sum;
    logic [W-1:0]      vcr_c, v0_c, best_len, remaining;
    logic [IW-1:0]     best_idx;
    logic [N_AXES-1:0] fire, busy, len_nz;

    for (genvar g = 0; g < N_AXES; g++) begin : g_lane
        assign num_a[g]   = num[lane_lsb(g, W) +: W];
        assign max_a[g]   = max_speed[lane_lsb(g, W) +: W];
        assign accel_a[g] = acceleration[lane_lsb(g, W) +: W];
        assign jerk_a[g]  = jerk[lane_lsb(g, W) +: W];
        assign len_nz[g]  = (len_q[g] != '0);

        step_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse (
            .clk  (clk),
            .reset(reset),
            .fire (fire[g]),
            .step (stepper_step[g]),
            .busy (busy[g])
        );
    end

    assign ready = (state_q == IDLE) && drv_on_q;

    // An endstop only counts on a moving axis, in its direction of travel.
    assign hit = |(len_nz & ((dir_q & endstop_max) | (~dir_q & endstop_min)));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        state_d = state_q;  drv_on_d = drv_on_q;  abort_d = abort_q;
        done_d = 1'b0;  aborted_d = 1'b0;  dir_d = dir_q;
        len_d = len_q;  max_d = max_q;  accel_d = accel_q;  jerk_d = jerk_q;  err_d = err_q;
        speed_d = speed_q;  l_d = l_q;  v_d = v_q;  v0_d = v0_q;  vcr_d = vcr_q;
        cnt_d = cnt_q;  accel_steps_d = accel_steps_q;  phase_d = phase_q;  vacc_d = vacc_q;
        dom_d = dom_q;  fire = '0;  fire_dom = 1'b0;  tick = 1'b0;  e_sum = '0;
        best_len = '0;  best_idx = '0;  vcr_c = '0;  v0_c = '0;  remaining = '0;
        phase_sum = phase_q + {1'b0, v_q};
        vacc_sum  = vacc_q + {1'b0, accel_q[dom_q]};

        // Disable wins over enable when both pulse together.
        if (disable_steppers)     drv_on_d = 1'b0;
        else if (enable_steppers) drv_on_d = 1'b1;

        case (state_q)
            IDLE: if (start && ready) begin
                state_d = LOAD;
                abort_d = 1'b0;
                speed_d = speed;
                for (int i = 0; i < N_AXES; i++) begin
                    len_d[i]   = num_a[i][W-1] ? -num_a[i] : num_a[i];
                    dir_d[i]   = !num_a[i][W-1] && (num_a[i] != '0);
                    max_d[i]   = max_a[i];
                    accel_d[i] = accel_a[i];
                    jerk_d[i]  = jerk_a[i];
                end
            end
            LOAD: begin
                // Strict compare keeps the lowest index on ties.
                for (int i = 0; i < N_AXES; i++) begin
                    if (len_q[i] > best_len) begin
                        best_len = len_q[i];
                        best_idx = IW'(i);
                    end
                end
                dom_d   = best_idx;
                l_d     = best_len;
                state_d = SELECT;
            end
            SELECT: begin
                vcr_c = (speed_q < max_q[dom_q]) ? speed_q : max_q[dom_q];
                v0_c  = (jerk_q[dom_q] < vcr_c) ? jerk_q[dom_q] : vcr_c;
                if (v0_c == '0) v0_c = W'(1);
                vcr_d = vcr_c;  v0_d = v0_c;  v_d = v0_c;
                // Preloaded phase makes the first dominant step fire immediately.
                phase_d = CLK_F;  vacc_d = '0;  cnt_d = '0;  accel_steps_d = '0;
                for (int i = 0; i < N_AXES; i++) err_d[i] = {2'b00, l_q[W-1:1]};
                state_d = (l_q == '0) ? DONE : ACCEL;
            end
            ACCEL, CRUISE, DECEL: begin
                if (hit || disable_steppers) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    fire_dom  = (phase_sum >= CLK_F);
                    phase_d   = fire_dom ? phase_sum - CLK_F : phase_sum;
                    tick      = (vacc_sum >= CLK_F);
                    vacc_d    = tick ? vacc_sum - CLK_F : vacc_sum;
                    remaining = l_q - cnt_q;
                    if (state_q == ACCEL) begin
                        if (tick && v_q < vcr_q) v_d = v_q + W'(1);
                        // Braking distance mirrors the distance spent accelerating.
                        if (remaining <= cnt_q) begin
                            state_d = DECEL;
                        end else if (v_q >= vcr_q) begin
                            state_d       = CRUISE;
                            accel_steps_d = cnt_q;
                        end
                    end else if (state_q == CRUISE) begin
                        if (remaining <= accel_steps_q) state_d = DECEL;
                    end else begin
                        if (tick && v_q > v0_q) v_d = v_q - W'(1);
                    end
                    if (fire_dom) begin
                        cnt_d = cnt_q + W'(1);
                        for (int i = 0; i < N_AXES; i++) begin
                            if (IW'(i) == dom_q) begin
                                fire[i] = 1'b1;
                            end else begin
                                e_sum = err_q[i] + {1'b0, len_q[i]};
                                if (e_sum >= {1'b0, l_q}) begin
                                    e_sum   = e_sum - {1'b0, l_q};
                                    fire[i] = 1'b1;
                                end
                                err_d[i] = e_sum;
                            end
                        end
                        if (cnt_d == l_q) state_d = DONE;
                    end
                end
            end
            DONE: if (busy == '0) begin
                done_d    = 1'b1;
                aborted_d = abort_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (disable_steppers && (state_q == LOAD || state_q == SELECT)) begin
            abort_d = 1'b1;
            state_d = DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            drv_on_q  <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            dir_q     <= '0;
        end else begin
            state_q   <= state_d;
            drv_on_q  <= drv_on_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            dir_q     <= dir_d;
        end
    end

    // NOTE: datapath registers are always loaded by a move before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        len_q   <= len_d;    max_q  <= max_d;   accel_q <= accel_d;  jerk_q <= jerk_d;
        err_q   <= err_d;    speed_q <= speed_d; l_q    <= l_d;      v_q    <= v_d;
        v0_q    <= v0_d;     vcr_q  <= vcr_d;   cnt_q   <= cnt_d;    dom_q  <= dom_d;
        phase_q <= phase_d;  vacc_q <= vacc_d;  accel_steps_q <= accel_steps_d;
    end

    assign stepper_enable    = {N_AXES{~drv_on_q}};
    assign stepper_direction = dir_q;
    assign done              = done_q;
    assign aborted           = aborted_q;

endmodule

// File: tb/tb_motion_profile_axes.sv
// ---------------------------------------------------------------------------
// tb_motion_profile_axes
//   Self-checking bench for motion_profile_axes (CLK_HZ=10_000, PULSE_CYCLES=2).
//   Each move pushes its expected step counts, directions and abort flag to a
//   scoreboard queue; the entry is popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_motion_profile_axes;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CH = 10_000;
    localparam int PC = 2;

    logic           clk = 1'b0;
    logic           reset, enable_steppers, disable_steppers, start, ready;
    logic [N*W-1:0] num, max_speed, acceleration, jerk;
    logic [W-1:0]   speed;
    logic [N-1:0]   endstop_min, endstop_max;
    logic [N-1:0]   stepper_enable, stepper_step, stepper_direction;
    logic           done, aborted;

    always #5 clk = ~clk;

    motion_profile_axes #(
        .N_AXES(N), .W(W), .CLK_HZ(CH), .PULSE_CYCLES(PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable_steppers  (enable_steppers),
        .disable_steppers (disable_steppers),
        .start            (start),
        .ready            (ready),
        .num              (num),
        .speed            (speed),
        .max_speed        (max_speed),
        .acceleration     (acceleration),
        .jerk             (jerk),
        .endstop_min      (endstop_min),
        .endstop_max      (endstop_max),
        .stepper_enable   (stepper_enable),
        .stepper_step     (stepper_step),
        .stepper_direction(stepper_direction),
        .done             (done),
        .aborted          (aborted)
    );

    typedef struct packed {
        logic [N-1:0][15:0] cnt;
        logic [N-1:0]       dir;
        logic               ab;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   dom_t[$];
    int   act_cnt[N];
    int   done_cyc;
    int   last_slave;

    task automatic pulse_enable();
        enable_steppers = 1'b1;
        @(negedge clk);
        enable_steppers = 1'b0;
        @(negedge clk);
    endtask

    // Runs one move to completion. ev_kind: 0 none, 1 endstop_min[0],
    // 2 endstop_max[0], 3 disable pulse -- raised once axis 0 has ev_at steps.
    task automatic run_move(input string tag, input int n[N], input int spd, input int accv,
                            input int ev_at, input int ev_kind, input int ecnt[N], input logic eab);
        exp_t         e;
        logic [N-1:0] prev;
        logic [N-1:0] got_dir;
        logic         got_ab;
        bit           got;
        bit           ev_fired;
        int           cyc;

        for (int i = 0; i < N; i++) begin
            e.cnt[i] = 16'(ecnt[i]);
            e.dir[i] = (n[i] > 0);
        end
        e.ab = eab;
        sb.push_back(e);

        speed = W'(spd);
        for (int i = 0; i < N; i++) begin
            num[i*W +: W]          = W'(n[i]);
            max_speed[i*W +: W]    = W'(2000);
            acceleration[i*W +: W] = W'(accv);
            jerk[i*W +: W]         = W'(100);
            act_cnt[i]             = 0;
        end
        dom_t.delete();
        last_slave = 0;
        done_cyc   = -1;
        got_dir    = '0;
        got_ab     = 1'b0;
        prev       = stepper_step;
        got        = 1'b0;
        ev_fired   = 1'b0;
        cyc        = 0;
        start      = 1'b1;

        while (!got && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start            = 1'b0;
            disable_steppers = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (stepper_step[i] && !prev[i]) begin
                    act_cnt[i]++;
                    if (i == 0) dom_t.push_back(cyc);
                    else        last_slave = cyc;
                end
            end
            prev = stepper_step;
            if (done) begin
                got      = 1'b1;
                done_cyc = cyc;
                got_ab   = aborted;
                got_dir  = stepper_direction;
            end else if (ev_kind != 0 && !ev_fired && act_cnt[0] == ev_at) begin
                ev_fired = 1'b1;
                case (ev_kind)
                    1:       endstop_min[0] = 1'b1;
                    2:       endstop_max[0] = 1'b1;
                    default: disable_steppers = 1'b1;
                endcase
            end
        end

        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", tag, cyc);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (act_cnt[i] !== int'(e.cnt[i])) begin
                    errors++;
                    $display("FAIL %s step_count[%0d]: got %0d expected %0d", tag, i, act_cnt[i], e.cnt[i]);
                end
            end
            checks++;
            if (got_dir !== e.dir) begin
                errors++;
                $display("FAIL %s direction: got %b expected %b", tag, got_dir, e.dir);
            end
            checks++;
            if (got_ab !== e.ab) begin
                errors++;
                $display("FAIL %s aborted: got %b expected %b", tag, got_ab, e.ab);
            end
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done still %b one cycle later, expected 0", tag, done);
        end
        endstop_min[0] = 1'b0;
        endstop_max[0] = 1'b0;
        if (ev_kind == 3) pulse_enable();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (stepper_enable !== 4'hF || stepper_step !== 4'h0 || stepper_direction !== 4'h0 ||
            done !== 1'b0 || aborted !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: en=%h step=%h dir=%h done=%b ab=%b ready=%b expected F 0 0 0 0 0",
                     stepper_enable, stepper_step, stepper_direction, done, aborted, ready);
        end
        reset = 1'b1;
        pulse_enable();
        checks++;
        if (ready !== 1'b1 || stepper_enable !== 4'h0) begin
            errors++;
            $display("FAIL enable_after_reset: ready=%b en=%h expected 1 0", ready, stepper_enable);
        end
    endtask

    task automatic test_coordinated();
        // Idle-axis endstops and an opposite-direction endstop must be ignored.
        endstop_min[2] = 1'b1;
        endstop_max[2] = 1'b1;
        endstop_max[3] = 1'b1;
        run_move("coord", '{100, 50, 0, -20}, 1000, 5000, 0, 0, '{100, 50, 0, 20}, 1'b0);
        endstop_min = '0;
        endstop_max = '0;
        checks++;
        if (dom_t.size() == 0 || dom_t[0] - 1 !== 3) begin
            errors++;
            $display("FAIL coord first_step_latency: got %0d expected 3",
                     (dom_t.size() == 0) ? -1 : dom_t[0] - 1);
        end
        checks++;
        if (dom_t.size() == 0 || last_slave > dom_t[dom_t.size()-1]) begin
            errors++;
            $display("FAIL coord slave_after_dominant: last slave %0d after last dominant", last_slave);
        end
        checks++;
        if (dom_t.size() == 0 || done_cyc !== dom_t[dom_t.size()-1] + PC + 1) begin
            errors++;
            $display("FAIL coord done_after_last_step: got cycle %0d expected %0d", done_cyc,
                     (dom_t.size() == 0) ? -1 : dom_t[dom_t.size()-1] + PC + 1);
        end
    endtask

    task automatic test_zero_move();
        run_move("zero", '{0, 0, 0, 0}, 1000, 5000, 0, 0, '{0, 0, 0, 0}, 1'b0);
        checks++;
        if (done_cyc - 1 !== 3) begin
            errors++;
            $display("FAIL zero done_latency: got %0d expected 3", done_cyc - 1);
        end
    endtask

    task automatic test_endstop();
        run_move("endstop_min", '{-40, 0, 0, 0}, 1000, 5000, 10, 1, '{10, 0, 0, 0}, 1'b1);
        run_move("endstop_max", '{-40, 0, 0, 0}, 1000, 5000, 10, 2, '{40, 0, 0, 0}, 1'b0);
    endtask

    task automatic test_triangle();
        int i0;
        int mid;
        int last;
        run_move("triangle", '{10, 0, 0, 0}, 1000, 5000, 0, 0, '{10, 0, 0, 0}, 1'b0);
        checks++;
        if (dom_t.size() != 10) begin
            errors++;
            $display("FAIL triangle intervals: got %0d step times expected 10", dom_t.size());
        end else begin
            i0   = dom_t[1] - dom_t[0];
            mid  = dom_t[5] - dom_t[4];
            last = dom_t[9] - dom_t[8];
            checks++;
            if (!(i0 > mid && last > mid)) begin
                errors++;
                $display("FAIL triangle shape: first=%0d mid=%0d last=%0d expected first,last > mid",
                         i0, mid, last);
            end
        end
    endtask

    task automatic test_disable_abort();
        run_move("disable_abort", '{100, 0, 0, 0}, 1000, 5000, 5, 3, '{5, 0, 0, 0}, 1'b1);
    endtask

    task automatic test_reset_mid_cruise();
        logic [N-1:0] prev;
        int           cyc;
        int           steps;
        int           extra;
        bit           saw_done;
        speed = W'(1000);
        for (int i = 0; i < N; i++) begin
            num[i*W +: W]          = (i == 0) ? W'(300) : '0;
            acceleration[i*W +: W] = W'(9000);
        end
        prev  = stepper_step;
        steps = 0;
        cyc   = 0;
        start = 1'b1;
        while (steps < 150 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (stepper_step[0] && !prev[0]) steps++;
            prev = stepper_step;
        end
        checks++;
        if (steps != 150) begin
            errors++;
            $display("FAIL reset_mid timeout: got %0d steps expected 150", steps);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (stepper_step !== 4'h0 || stepper_enable !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid state: step=%h en=%h ready=%b expected 0 F 0",
                     stepper_step, stepper_enable, ready);
        end
        reset    = 1'b1;
        prev     = stepper_step;
        extra    = 0;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            extra += $countones(stepper_step & ~prev);
            prev = stepper_step;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (extra != 0 || saw_done || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet: steps=%0d done_seen=%b ready=%b expected 0 0 0",
                     extra, saw_done, ready);
        end
        pulse_enable();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid reenable: ready=%b expected 1", ready);
        end
    endtask

    task automatic test_both_pulses();
        logic [N-1:0] prev;
        int           extra;
        bit           saw_done;
        enable_steppers  = 1'b1;
        disable_steppers = 1'b1;
        @(negedge clk);
        enable_steppers  = 1'b0;
        disable_steppers = 1'b0;
        @(negedge clk);
        checks++;
        if (stepper_enable !== 4'hF || ready !== 1'b0) begin
            errors++;
            $display("FAIL both_pulses enable: en=%h ready=%b expected F 0", stepper_enable, ready);
        end
        for (int i = 0; i < N; i++) num[i*W +: W] = W'(20);
        start    = 1'b1;
        prev     = stepper_step;
        extra    = 0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            start = 1'b0;
            extra += $countones(stepper_step & ~prev);
            prev = stepper_step;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (extra != 0 || saw_done) begin
            errors++;
            $display("FAIL both_pulses start_ignored: steps=%0d done_seen=%b expected 0 0", extra, saw_done);
        end
        pulse_enable();
    endtask

    initial begin
        reset            = 1'b0;
        enable_steppers  = 1'b0;
        disable_steppers = 1'b0;
        start            = 1'b0;
        num              = '0;
        speed            = '0;
        max_speed        = '0;
        acceleration     = '0;
        jerk             = '0;
        endstop_min      = '0;
        endstop_max      = '0;
        @(negedge clk);

        test_reset();
        test_coordinated();
        test_zero_move();
        test_endstop();
        test_triangle();
        test_disable_abort();
        test_reset_mid_cruise();
        test_both_pulses();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
